// File: rtl/status_reg_if.sv
// ALU-flag / control bus between the 6502 controller (master) and the status register (slave).
// Carries the per-op flag update request, flag/load/interrupt controls, and the visible P outputs.
interface status_reg_if;
  logic       upd_en;
  logic [7:0] upd_mask;
  logic [7:0] alu_status;
  logic       flag_op_en;
  logic [2:0] flag_op;
  logic       load_en;
  logic [7:0] db_in;
  logic       irq_entry;
  logic       brk_push;
  logic [7:0] p;
  logic [7:0] p_push;
  logic       pend;

  modport master (
    output upd_en, upd_mask, alu_status, flag_op_en, flag_op,
           load_en, db_in, irq_entry, brk_push,
    input  p, p_push, pend
  );

  modport slave (
    input  upd_en, upd_mask, alu_status, flag_op_en, flag_op,
           load_en, db_in, irq_entry, brk_push,
    output p, p_push, pend
  );
endinterface

// File: rtl/status_reg.sv
// 6502 P register: ALU flags merge 2 cycles after issue (1 with STATUS_BYPASS_EN); no backpressure.
// Per-bit priority rst > load > irq_entry > flag_op > pending ALU apply; bit5 always 1, bit4 never stored.
module status_reg #(
  parameter logic [7:0] RESET_P = 8'h24
) (
  input logic         clk,
  input logic         rst,
  status_reg_if.slave bus
);

  localparam logic [7:0] ALU_BITS = 8'hC3;

  logic [7:0] p_q, p_d;
  logic [7:0] pmask_q, pmask_d;
  logic       pend_q, pend_d;
  logic [7:0] p_vis;

  // Lowest-priority source is written first so higher ones overwrite only their own bits.
  always_comb begin
    p_d = p_q;
    if (pend_q) begin
      p_d = (p_q & ~pmask_q) | (bus.alu_status & pmask_q);
    end
    if (bus.flag_op_en) begin
      case (bus.flag_op)
        3'b000:  p_d[0] = 1'b0;
        3'b001:  p_d[0] = 1'b1;
        3'b010:  p_d[2] = 1'b0;
        3'b011:  p_d[2] = 1'b1;
        3'b100:  p_d[6] = 1'b0;
        3'b101:  p_d[3] = 1'b0;
        3'b110:  p_d[3] = 1'b1;
        default: ;
      endcase
    end
    if (bus.irq_entry) begin
      p_d[2] = 1'b1;
    end
    if (bus.load_en) begin
      p_d = {bus.db_in[7:6], 1'b1, p_q[4], bus.db_in[3:0]};
    end
    p_d[5] = 1'b1;
    p_d[4] = 1'b0;

    pend_d  = bus.upd_en & ~bus.load_en;
    pmask_d = pend_d ? (bus.upd_mask & ALU_BITS) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q     <= (RESET_P | 8'h20) & 8'hEF;
      pmask_q <= 8'h00;
      pend_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      pmask_q <= pmask_d;
      pend_q  <= pend_d;
    end
  end

`ifdef STATUS_BYPASS_EN
  assign p_vis = pend_q ? ((p_q & ~pmask_q) | (bus.alu_status & pmask_q)) : p_q;
`else
  assign p_vis = p_q;
`endif

  assign bus.p      = p_vis;
  assign bus.p_push = {p_vis[7:6], 1'b1, bus.brk_push, p_vis[3:0]};
  assign bus.pend   = pend_q;

endmodule

// File: tb/tb_status_reg.sv
// Bench for status_reg: directed vector table, hand sequences, then random stimulus vs a reference model.
module tb_status_reg;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  status_reg_if bus ();
  status_reg #(.RESET_P(8'h24)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       upd_en;
    logic [7:0] upd_mask;
    logic [7:0] alu;
    logic       fen;
    logic [2:0] fop;
    logic       ld;
    logic [7:0] db;
    logic       irq;
    logic       brk;
    logic [7:0] exp_p;
    logic       exp_pend;
    logic [7:0] exp_push;
  } vec_t;

  vec_t vecs[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic ue, input logic [7:0] um, input logic [7:0] alu,
                     input logic fen, input logic [2:0] fop, input logic ld, input logic [7:0] db,
                     input logic irq, input logic brk, input logic [7:0] ep, input logic epend,
                     input logic [7:0] epush);
    vec_t v;
    v.rst = r; v.upd_en = ue; v.upd_mask = um; v.alu = alu; v.fen = fen; v.fop = fop;
    v.ld = ld; v.db = db; v.irq = irq; v.brk = brk;
    v.exp_p = ep; v.exp_pend = epend; v.exp_push = epush;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic ue, input logic [7:0] um, input logic [7:0] alu,
                       input logic fen, input logic [2:0] fop, input logic ld, input logic [7:0] db,
                       input logic irq, input logic brk);
    rst = r; bus.upd_en = ue; bus.upd_mask = um; bus.alu_status = alu;
    bus.flag_op_en = fen; bus.flag_op = fop; bus.load_en = ld; bus.db_in = db;
    bus.irq_entry = irq; bus.brk_push = brk;
  endtask

  // Reference model: architectural P plus the masks still waiting for their ALU cycle.
  localparam logic [7:0] RST_VAL = 8'h24;
  int         fbit[7] = '{0, 0, 2, 2, 6, 3, 3};
  logic       fval[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] m_p;
  logic [7:0] m_q[$];

  function automatic logic [7:0] model_visible();
    logic [7:0] v;
    v = m_p;
`ifdef STATUS_BYPASS_EN
    if (m_q.size() > 0)
      for (int i = 0; i < 8; i++)
        if (m_q[0][i]) v[i] = bus.alu_status[i];
`endif
    return v;
  endfunction

  task automatic model_edge();
    logic [7:0] np;
    logic [7:0] mask;
    mask = (m_q.size() > 0) ? m_q[0] : 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (rst)                                   np[i] = RST_VAL[i];
      else if (i == 5)                           np[i] = 1'b1;
      else if (i == 4)                           np[i] = 1'b0;
      else if (bus.load_en)                      np[i] = bus.db_in[i];
      else if (bus.irq_entry && i == 2)          np[i] = 1'b1;
      else if (bus.flag_op_en && bus.flag_op != 3'b111 && fbit[bus.flag_op] == i)
                                                 np[i] = fval[bus.flag_op];
      else if (mask[i] && (i == 0 || i == 1 || i == 6 || i == 7))
                                                 np[i] = bus.alu_status[i];
      else                                       np[i] = m_p[i];
    end
    m_p = np;
    m_q.delete();
    if (!rst && !bus.load_en && bus.upd_en) m_q.push_back(bus.upd_mask & 8'hC3);
  endtask

  initial begin
    logic [7:0] exp_v;
    drive(1'b1, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 1'b1);

    //   rst ue mask   alu    fen fop   ld db     irq brk  p      pend push
    add(1, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 1, 8'h24, 0, 8'h34);
    add(1, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 1, 8'h24, 0, 8'h34);
    add(0, 1, 8'h82, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'h24, 1, 8'h24);
    add(0, 0, 8'h00, 8'h82, 0, 3'd7, 0, 8'h00, 0, 1, 8'hA6, 0, 8'hB6);
    add(0, 1, 8'h01, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'hA6, 1, 8'hA6);
    add(0, 1, 8'h01, 8'h01, 0, 3'd7, 0, 8'h00, 0, 0, 8'hA7, 1, 8'hA7);
    add(0, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'hA6, 0, 8'hA6);
    add(0, 1, 8'h01, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'hA6, 1, 8'hA6);
    add(0, 0, 8'h00, 8'h01, 1, 3'd0, 0, 8'h00, 0, 0, 8'hA6, 0, 8'hA6);
    add(0, 1, 8'h01, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'hA6, 1, 8'hA6);
    add(0, 1, 8'hC3, 8'h01, 0, 3'd7, 1, 8'hFF, 0, 1, 8'hEF, 0, 8'hFF);
    add(0, 0, 8'h00, 8'hFF, 0, 3'd7, 0, 8'h00, 0, 0, 8'hEF, 0, 8'hEF);
    add(0, 0, 8'h00, 8'h00, 0, 3'd7, 1, 8'h00, 0, 0, 8'h20, 0, 8'h20);
    add(0, 0, 8'h00, 8'h00, 1, 3'd1, 0, 8'h00, 0, 0, 8'h21, 0, 8'h21);
    add(0, 0, 8'h00, 8'h00, 1, 3'd6, 0, 8'h00, 0, 0, 8'h29, 0, 8'h29);
    add(0, 0, 8'h00, 8'h00, 1, 3'd3, 0, 8'h00, 0, 0, 8'h2D, 0, 8'h2D);
    add(0, 0, 8'h00, 8'h00, 1, 3'd7, 0, 8'h00, 0, 0, 8'h2D, 0, 8'h2D);
    add(0, 0, 8'h00, 8'h00, 1, 3'd2, 0, 8'h00, 0, 0, 8'h29, 0, 8'h29);
    add(0, 0, 8'h00, 8'h00, 1, 3'd5, 0, 8'h00, 0, 0, 8'h21, 0, 8'h21);
    add(0, 0, 8'h00, 8'h00, 1, 3'd0, 0, 8'h00, 0, 0, 8'h20, 0, 8'h20);
    add(0, 0, 8'h00, 8'h00, 0, 3'd7, 1, 8'hC0, 0, 0, 8'hE0, 0, 8'hE0);
    add(0, 0, 8'h00, 8'h00, 1, 3'd4, 0, 8'h00, 0, 0, 8'hA0, 0, 8'hA0);
    add(0, 0, 8'h00, 8'h00, 0, 3'd7, 1, 8'h10, 0, 0, 8'h20, 0, 8'h20);
    add(0, 0, 8'h00, 8'h00, 1, 3'd2, 0, 8'h00, 1, 0, 8'h24, 0, 8'h24);
    add(0, 0, 8'h00, 8'h00, 0, 3'd7, 1, 8'h00, 1, 0, 8'h20, 0, 8'h20);
    add(0, 1, 8'hFF, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'h20, 1, 8'h20);
    add(0, 0, 8'h00, 8'hFF, 1, 3'd0, 0, 8'h00, 0, 0, 8'hE2, 0, 8'hE2);
    add(0, 1, 8'hFF, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'hE2, 1, 8'hE2);
    add(1, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0, 8'h24, 0, 8'h24);
    add(0, 0, 8'h00, 8'hFF, 0, 3'd7, 0, 8'h00, 0, 0, 8'h24, 0, 8'h24);

`ifndef STATUS_BYPASS_EN
    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].rst, vecs[k].upd_en, vecs[k].upd_mask, vecs[k].alu, vecs[k].fen,
            vecs[k].fop, vecs[k].ld, vecs[k].db, vecs[k].irq, vecs[k].brk);
      @(posedge clk); #1;
      check8($sformatf("vec%0d_p", k), bus.p, vecs[k].exp_p);
      check8($sformatf("vec%0d_pend", k), {7'd0, bus.pend}, {7'd0, vecs[k].exp_pend});
      check8($sformatf("vec%0d_push", k), bus.p_push, vecs[k].exp_push);
    end
`endif

    // Interrupt entry: push byte before and after the edge.
    drive(0, 0, 8'h00, 8'h00, 0, 3'd7, 1, 8'h00, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 1, 0);
    #1;
    check8("irq_push_before", bus.p_push, 8'h20);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0);
    #1;
    check8("irq_p_after", bus.p, 8'h24);
    check8("irq_push_after", bus.p_push, 8'h24);

    // Z visibility: N+1 with bypass, N+2 without.
    drive(0, 1, 8'h02, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h02, 0, 3'd7, 0, 8'h00, 0, 0);
    #1;
`ifdef STATUS_BYPASS_EN
    check8("z_n1", {7'd0, bus.p[1]}, 8'h01);
`else
    check8("z_n1", {7'd0, bus.p[1]}, 8'h00);
`endif
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 0, 3'd7, 0, 8'h00, 0, 0);
    #1;
    check8("z_n2", {7'd0, bus.p[1]}, 8'h01);
    @(posedge clk); #1;

    // Random stimulus against the reference model.
    for (int k = 0; k < 3000; k++) begin
      drive((k == 0) || ($urandom_range(49) == 0),
            $urandom_range(1), 8'($urandom), 8'($urandom),
            $urandom_range(2) == 0, 3'($urandom), $urandom_range(9) == 0, 8'($urandom),
            $urandom_range(7) == 0, $urandom_range(1));
      #1;
      if (k > 0) begin
        exp_v = model_visible();
        check8("rand_p", bus.p, exp_v);
        check8("rand_pend", {7'd0, bus.pend}, {7'd0, (m_q.size() > 0)});
        check8("rand_push", bus.p_push, {exp_v[7:6], 1'b1, bus.brk_push, exp_v[3:0]});
      end
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/status_reg.md
Name: status_reg

Overview:
- 6502 processor status register (P). Consumer end of the ALU flag interface.
- The ALU registers its N/V/Z/C status one cycle after an op is issued. This block captures the controller's per-op flag-update mask in the issue cycle, then merges the ALU flags into P when they arrive.
- Also handles explicit flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED), PLP/RTI loads from the data bus, interrupt-entry I-set, and the PHP/BRK push byte.

Parameters:
- RESET_P, 8'h24, P value after reset (I=1, bit5=1). Bit5 is forced to 1 regardless.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- upd_en  in  1  ALU op issued this cycle; capture upd_mask
- upd_mask  in  8  P bit positions to take from ALU status next cycle; only bits 7,6,1,0 are honoured
- alu_status  in  8  registered ALU flags: [7]=N, [6]=V, [1]=Z, [0]=C
- flag_op_en  in  1  execute flag instruction
- flag_op  in  3  000 CLC, 001 SEC, 010 CLI, 011 SEI, 100 CLV, 101 CLD, 110 SED, 111 no-op
- load_en  in  1  PLP/RTI: load P from db_in
- db_in  in  8  pulled byte
- irq_entry  in  1  interrupt/BRK entry: set I
- brk_push  in  1  selects B=1 in p_push (BRK/PHP) vs B=0 (IRQ/NMI)
- p  out  8  current status register
- p_push  out  8  byte for stack push
- pend  out  1  ALU update pending (mask captured, not yet applied)

Behaviour:
- Reset: p=RESET_P|8'h20, pending mask=0, pend=0. Reset wins over every other input. Reset mid-update discards the pending mask.
- Capture: on a clk edge with upd_en=1, pmask <= upd_mask & 8'hC3 and pend <= 1. Otherwise pend <= 0.
- Apply: in the cycle where pend=1, at the edge, p[i] <= alu_status[i] for each i with pmask[i]=1.
- Back-to-back upd_en every cycle is supported: each edge applies the old mask and captures the new one.
- Latency: ALU flags issued in cycle N are visible on p in cycle N+2 (registered). See the optional feature for the bypass path.
- Flag op: sets or clears a single bit (C=0, I=2, V=6, D=3). 111 has no effect.
- Load: p <= db_in with bit4 ignored (p[4] holds its value) and bit5 forced to 1.
- irq_entry: p[2] <= 1.
- Priority on the same edge, per bit, highest first: rst > load_en > irq_entry > flag_op > pending ALU apply. A lower-priority source never alters bits written by a higher one; other bits still update.
- Load clears any pending apply (pend/pmask <= 0), even if upd_en is also high.
- p_push is combinational from the currently visible P: p with bit5=1 and bit4=brk_push.
- p[5]=1 at all times. p[4] in the stored register is always 0.

Optional Feature:
- Macro: STATUS_BYPASS_EN.
- Defined: p is combinational. It equals the registered P merged with alu_status under pmask whenever pend=1, so ALU flags are visible in cycle N+1 for same-cycle branch evaluation. p_push uses the bypassed value. Register update timing is unchanged.
- Undefined: p is the pure register output, with 2-cycle visibility.

Test Plan:
- Reset: rst=1 for 2 cycles -> p=8'h24, pend=0, p_push with brk_push=1 = 8'h34.
- ALU apply: upd_en=1, upd_mask=8'h82 in cycle N; alu_status=8'h82 in N+1 -> p=8'hA6 in N+2 and pend=1 in N+1. V and C are untouched.
- Back-to-back: mask 8'h01 with alu C=1, then mask 8'h01 with alu C=0 on consecutive cycles -> p[0] reads 1 then 0 on consecutive cycles. No update is lost.
- Conflict: pending C update (alu C=1) coincides with flag_op=000 (CLC) -> p[0]=0. Same edge with load_en=1, db_in=8'hFF -> p=8'hEF, pend=0.
- Interrupt: irq_entry=1 with brk_push=0 while p=8'h20 -> p=8'h24. p_push before the edge is 8'h20; after the edge it is 8'h24.
- Bypass (STATUS_BYPASS_EN): mask 8'h02, alu Z=1 -> p[1]=1 in N+1; without the macro -> p[1]=1 only in N+2.
